// File: rtl/fifo_sync_if.sv
// fifo_sync_if -- handshake and status bundle for fifo_sync.
//
// Parameters:
//   WIDTH     : data word width in bits
//   ADDR_BITS : log2 of FIFO depth (usedw is ADDR_BITS+1 bits wide)
//
// Signals:
//   data, wrreq             : write side (driven by the master)
//   rdreq                   : read request / head acknowledge (master)
//   q                       : read data (FIFO)
//   full, empty             : registered occupancy flags (FIFO)
//   almost_full/empty       : registered threshold flags (FIFO)
//   usedw                   : word count 0..DEPTH (FIFO)
//   overflow, underflow     : sticky error flags (FIFO)
//
// Modports: master = FIFO user, slave = FIFO itself.

interface fifo_sync_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 10
);

  logic [WIDTH-1:0]   data;
  logic               wrreq;
  logic               rdreq;
  logic [WIDTH-1:0]   q;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [ADDR_BITS:0] usedw;
  logic               overflow;
  logic               underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with registered status flags.
//
// Parameters:
//   WIDTH         : data word width
//   DEPTH         : number of storage words (power of two, >= 4)
//   ADDR_BITS     : log2(DEPTH)
//   AFULL_THRESH  : almost_full when usedw >= this
//   AEMPTY_THRESH : almost_empty when usedw <= this
//   SHOWAHEAD     : 0 = registered read, 1 = first-word-fall-through
//
// Ports:
//   clock : sole clock, rising edge
//   aclr  : asynchronous active-high reset
//   sclr  : synchronous clear, overrides wrreq/rdreq
//   bus   : fifo_sync_if.slave (data/wrreq/rdreq in, q/flags/usedw out)
//
// Optional feature macro: FIFO_SYNC_ERRFLAGS_EN
//   defined   -> sticky overflow/underflow flags are implemented
//   undefined -> overflow/underflow are tied to 0

module fifo_sync #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 1024,
  parameter int ADDR_BITS     = 10,
  parameter int AFULL_THRESH  = 1020,
  parameter int AEMPTY_THRESH = 4,
  parameter int SHOWAHEAD     = 0
) (
  input logic        clock,
  input logic        aclr,
  input logic        sclr,
  fifo_sync_if.slave bus
);

  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AF_LVL   = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0]   AE_LVL   = (ADDR_BITS+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wrptr;
  logic [ADDR_BITS-1:0] rdptr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   count_next;
  logic                 full_r;
  logic                 empty_r;
  logic                 afull_r;
  logic                 aempty_r;
  logic                 wr_acc;
  logic                 rd_acc;

  // Acceptance is qualified by the registered flags, so a write into a
  // full FIFO or a read from an empty one is simply ignored; a
  // simultaneous read on full / write on empty still goes through.
  assign wr_acc = bus.wrreq & ~full_r;
  assign rd_acc = bus.rdreq & ~empty_r;

  // Next occupancy; a simultaneous accepted read and write cancels out.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointers, count and flags. Flags are computed from the next count so
  // that they are registered yet always agree with usedw in the same cycle.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else if (sclr) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      if (wr_acc) wrptr <= wrptr + PTR_ONE;
      if (rd_acc) rdptr <= rdptr + PTR_ONE;
      count    <= count_next;
      full_r   <= (count_next == CNT_FULL);
      empty_r  <= (count_next == '0);
      afull_r  <= (count_next >= AF_LVL);
      aempty_r <= (count_next <= AE_LVL);
    end
  end

  // Storage array, deliberately not reset. The write is suppressed on an
  // edge where a clear is active so an aborted transfer leaves no trace.
  always_ff @(posedge clock) begin
    if (wr_acc && !sclr && !aclr) mem[wrptr] <= bus.data;
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head word is read combinationally from the array; it is forced to
      // zero while empty so the output is well defined after reset/clear.
      assign bus.q = empty_r ? '0 : mem[rdptr];
    end else begin : g_registered
      logic [WIDTH-1:0] q_r;

      // Output register loads only on an accepted read and holds otherwise.
      always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
          q_r <= '0;
        end else if (sclr) begin
          q_r <= '0;
        end else if (rd_acc) begin
          q_r <= mem[rdptr];
        end
      end

      assign bus.q = q_r;
    end
  endgenerate

`ifdef FIFO_SYNC_ERRFLAGS_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags: any request against the wrong flag sets them and
  // only a reset or synchronous clear brings them back down.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (sclr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (bus.wrreq && full_r)  ovf_r <= 1'b1;
      if (bus.rdreq && empty_r) udf_r <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_r;
  assign bus.underflow = udf_r;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.usedw        = count;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync -- self-checking bench for fifo_sync.
//
// Instantiates a registered-read FIFO (DEPTH=16, AFULL=12, AEMPTY=2) and a
// show-ahead FIFO (DEPTH=16). Expected overflow/underflow values follow
// whether FIFO_SYNC_ERRFLAGS_EN is defined for the build.

module tb_fifo_sync;

`ifdef FIFO_SYNC_ERRFLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clock;
  logic aclr;
  logic sclr;

  int total_checks;
  int passed_checks;

  fifo_sync_if #(.WIDTH(16), .ADDR_BITS(4)) bus ();
  fifo_sync_if #(.WIDTH(16), .ADDR_BITS(4)) sa_bus ();

  fifo_sync #(
    .WIDTH(16), .DEPTH(16), .ADDR_BITS(4),
    .AFULL_THRESH(12), .AEMPTY_THRESH(2), .SHOWAHEAD(0)
  ) dut (
    .clock(clock), .aclr(aclr), .sclr(sclr), .bus(bus)
  );

  fifo_sync #(
    .WIDTH(16), .DEPTH(16), .ADDR_BITS(4),
    .AFULL_THRESH(12), .AEMPTY_THRESH(2), .SHOWAHEAD(1)
  ) dut_sa (
    .clock(clock), .aclr(aclr), .sclr(sclr), .bus(sa_bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] din;
    logic [4:0]  usedw;
    logic        empty;
    logic        full;
    logic        ae;
    logic        af;
    logic [15:0] q;
    logic        udf;
  } vec_t;

  vec_t vecs [13];

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the main FIFO for one clock and land #1 after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [15:0] d);
    bus.wrreq = w;
    bus.rdreq = r;
    sclr      = c;
    bus.data  = d;
    @(posedge clock);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    sclr      = 1'b0;
  endtask

  // Drive the show-ahead FIFO for one clock.
  task automatic applySa(input logic w, input logic r, input logic [15:0] d);
    sa_bus.wrreq = w;
    sa_bus.rdreq = r;
    sa_bus.data  = d;
    @(posedge clock);
    #1;
    sa_bus.wrreq = 1'b0;
    sa_bus.rdreq = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    aclr          = 1'b1;
    sclr          = 1'b0;
    bus.wrreq     = 1'b0;
    bus.rdreq     = 1'b0;
    bus.data      = '0;
    sa_bus.wrreq  = 1'b0;
    sa_bus.rdreq  = 1'b0;
    sa_bus.data   = '0;

    //            wr rd clr din       usedw emp full ae af q         udf
    vecs[0]  = '{1, 0, 0, 16'h1111, 5'd1, 0, 0, 1, 0, 16'h0000, 1'b0};
    vecs[1]  = '{1, 0, 0, 16'h2222, 5'd2, 0, 0, 1, 0, 16'h0000, 1'b0};
    vecs[2]  = '{1, 0, 0, 16'h3333, 5'd3, 0, 0, 0, 0, 16'h0000, 1'b0};
    vecs[3]  = '{0, 1, 0, 16'h0000, 5'd2, 0, 0, 1, 0, 16'h1111, 1'b0};
    vecs[4]  = '{1, 1, 0, 16'h4444, 5'd2, 0, 0, 1, 0, 16'h2222, 1'b0};
    vecs[5]  = '{0, 0, 0, 16'h0000, 5'd2, 0, 0, 1, 0, 16'h2222, 1'b0};
    vecs[6]  = '{0, 1, 0, 16'h0000, 5'd1, 0, 0, 1, 0, 16'h3333, 1'b0};
    vecs[7]  = '{0, 1, 0, 16'h0000, 5'd0, 1, 0, 1, 0, 16'h4444, 1'b0};
    vecs[8]  = '{0, 1, 0, 16'h0000, 5'd0, 1, 0, 1, 0, 16'h4444, ERR};
    vecs[9]  = '{1, 1, 0, 16'h5555, 5'd1, 0, 0, 1, 0, 16'h4444, ERR};
    vecs[10] = '{1, 0, 1, 16'h9999, 5'd0, 1, 0, 1, 0, 16'h0000, 1'b0};
    vecs[11] = '{1, 0, 0, 16'h6666, 5'd1, 0, 0, 1, 0, 16'h0000, 1'b0};
    vecs[12] = '{0, 1, 1, 16'h0000, 5'd0, 1, 0, 1, 0, 16'h0000, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    aclr = 1'b0;

    // Reset state
    checkOutput("rst_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_ae", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst_af", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_q", 32'(bus.q), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_udf", 32'(bus.underflow), 32'd0);
    checkOutput("sa_rst_empty", 32'(sa_bus.empty), 32'd1);

    // Show-ahead: head word visible the cycle after the first write
    applySa(1'b1, 1'b0, 16'hABCD);
    checkOutput("sa_empty", 32'(sa_bus.empty), 32'd0);
    checkOutput("sa_q_first", 32'(sa_bus.q), 32'hABCD);
    checkOutput("sa_usedw", 32'(sa_bus.usedw), 32'd1);
    applySa(1'b1, 1'b0, 16'h1234);
    checkOutput("sa_q_hold", 32'(sa_bus.q), 32'hABCD);
    applySa(1'b0, 1'b1, 16'h0000);
    checkOutput("sa_q_next", 32'(sa_bus.q), 32'h1234);
    checkOutput("sa_usedw2", 32'(sa_bus.usedw), 32'd1);
    applySa(1'b0, 1'b1, 16'h0000);
    checkOutput("sa_drained", 32'(sa_bus.empty), 32'd1);

    // Table-driven vectors on the registered-read FIFO
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      checkOutput($sformatf("v%0d_usedw", i), 32'(bus.usedw), 32'(vecs[i].usedw));
      checkOutput($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      checkOutput($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].full));
      checkOutput($sformatf("v%0d_ae", i), 32'(bus.almost_empty), 32'(vecs[i].ae));
      checkOutput($sformatf("v%0d_af", i), 32'(bus.almost_full), 32'(vecs[i].af));
      checkOutput($sformatf("v%0d_q", i), 32'(bus.q), 32'(vecs[i].q));
      checkOutput($sformatf("v%0d_udf", i), 32'(bus.underflow), 32'(vecs[i].udf));
    end

    // Fill with 0x0001..0x0010, tracking threshold flags step by step
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'(k));
      checkOutput($sformatf("fill%0d_usedw", k), 32'(bus.usedw), 32'(k));
      checkOutput($sformatf("fill%0d_ae", k), 32'(bus.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d_af", k), 32'(bus.almost_full), (k >= 12) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d_full", k), 32'(bus.full), (k == 16) ? 32'd1 : 32'd0);
    end
    checkOutput("fill_ovf", 32'(bus.overflow), 32'd0);

    // Write while full: dropped, overflow raised when enabled
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("ovf_usedw", 32'(bus.usedw), 32'd16);
    checkOutput("ovf_full", 32'(bus.full), 32'd1);
    checkOutput("ovf_set", 32'(bus.overflow), 32'(ERR));

    // Simultaneous access while full: only the read is accepted
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hDEAD);
    checkOutput("fullrw_usedw", 32'(bus.usedw), 32'd15);
    checkOutput("fullrw_full", 32'(bus.full), 32'd0);
    checkOutput("fullrw_q", 32'(bus.q), 32'h0001);
    checkOutput("ovf_sticky", 32'(bus.overflow), 32'(ERR));

    // Drain the remaining 15 words in order; 0xBEEF/0xDEAD must not appear
    for (int j = 2; j <= 16; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput($sformatf("drain%0d_q", j), 32'(bus.q), 32'(j));
      checkOutput($sformatf("drain%0d_usedw", j), 32'(bus.usedw), 32'(16 - j));
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Wrap: 40 words streamed through with one word in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1000);
    for (int i = 1; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(16'h1000 + i * 7));
      checkOutput($sformatf("wrap%0d_q", i), 32'(bus.q), 32'(16'h1000 + (i - 1) * 7));
      checkOutput($sformatf("wrap%0d_usedw", i), 32'(bus.usedw), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_last_q", 32'(bus.q), 32'(16'h1000 + 39 * 7));
    checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

    // aclr mid-stream: immediate reset, write on that edge aborted
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0A0A);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0B0B);
    checkOutput("pre_aclr_usedw", 32'(bus.usedw), 32'd2);
    checkOutput("pre_aclr_ovf", 32'(bus.overflow), 32'(ERR));
    bus.wrreq = 1'b1;
    bus.data  = 16'h0C0C;
    #3;
    aclr = 1'b1;
    #1;
    checkOutput("aclr_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("aclr_empty", 32'(bus.empty), 32'd1);
    checkOutput("aclr_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("aclr_q", 32'(bus.q), 32'd0);
    @(posedge clock);
    #1;
    aclr      = 1'b0;
    bus.wrreq = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("post_aclr_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("post_aclr_empty", 32'(bus.empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h7777);
    checkOutput("post_aclr_wr", 32'(bus.usedw), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("post_aclr_q", 32'(bus.q), 32'h7777);
    checkOutput("post_aclr_drain", 32'(bus.empty), 32'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 1024: storage words; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_BITS, default 10: log2(DEPTH).
REQ-004 Parameter AFULL_THRESH, default 1020: almost_full asserts at usedw >= this value.
REQ-005 Parameter AEMPTY_THRESH, default 4: almost_empty asserts at usedw <= this value.
REQ-006 Parameter SHOWAHEAD, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-007 Single clock domain; reset asynchronous, active-high.
REQ-008 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-009 Port aclr, input, 1: asynchronous active-high reset.
REQ-010 Port sclr, input, 1: synchronous clear.
REQ-011 Port data, input, WIDTH: write data.
REQ-012 Port wrreq, input, 1: write request.
REQ-013 Port rdreq, input, 1: read request (in show-ahead mode, acknowledge of head word).
REQ-014 Port q, output, WIDTH: read data.
REQ-015 Port full, output, 1; port empty, output, 1.
REQ-016 Port almost_full, output, 1; port almost_empty, output, 1.
REQ-017 Port usedw, output, ADDR_BITS+1: word count, 0..DEPTH inclusive, never wraps.
REQ-018 Port overflow, output, 1; port underflow, output, 1: sticky error flags.

Function
REQ-019 A write SHALL be accepted iff wrreq=1 and full=0; data is stored at the write pointer, which advances modulo DEPTH.
REQ-020 A read SHALL be accepted iff rdreq=1 and empty=0; the read pointer advances modulo DEPTH.
REQ-021 usedw SHALL increase by 1 on accepted write only, decrease by 1 on accepted read only, and stay unchanged when both are accepted.
REQ-022 When full, wrreq+rdreq SHALL accept only the read (usedw DEPTH -> DEPTH-1). When empty, wrreq+rdreq SHALL accept only the write (usedw 0 -> 1).
REQ-023 full, empty, almost_full and almost_empty SHALL be registered and consistent with usedw in the same cycle: full = (usedw==DEPTH), empty = (usedw==0).
REQ-024 empty SHALL deassert on the first clock edge after an accepted write into an empty FIFO.
REQ-025 SHOWAHEAD=0: q SHALL present the read word one clock after the accepted read, and SHALL hold its value otherwise.
REQ-026 SHOWAHEAD=1: whenever empty=0, q SHALL present the oldest stored word. An accepted read SHALL expose the next word in the following cycle. q is undefined while empty=1.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering.
REQ-028 sclr=1 SHALL override wrreq and rdreq: pointers and usedw go to 0, flags go to their reset values, and q goes to 0. Memory contents are not required to be cleared.

Reset
REQ-029 aclr=1 SHALL immediately set: usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, q=0, overflow=0, underflow=0, both pointers=0.
REQ-030 aclr asserted mid-transfer SHALL abort any write or read on that edge; after release, the FIFO behaves as empty.
REQ-031 Memory array SHALL NOT be reset.

Configuration
REQ-032 Macro FIFO_SYNC_ERRFLAGS_EN, when defined: overflow sets on any cycle with wrreq=1 and full=1, and underflow sets on any cycle with rdreq=1 and empty=1. Both are sticky until aclr or sclr.
REQ-033 Macro FIFO_SYNC_ERRFLAGS_EN undefined: the overflow and underflow ports SHALL exist and be tied to 0, with no error logic synthesized.

Verification
REQ-034 Fill and drain: DEPTH=16. Write 0x0001..0x0010 -> full=1 and usedw=16. Read 16 -> data returned in order, then empty=1 and usedw=0.
REQ-035 Simultaneous access: at usedw=16 (full), wrreq+rdreq -> usedw=15 and the written word is dropped. At usedw=0, wrreq+rdreq -> usedw=1 and q unchanged.
REQ-036 Thresholds: AFULL_THRESH=12, AEMPTY_THRESH=2. Step writes -> almost_empty drops at usedw=3 and almost_full rises at usedw=12.
REQ-037 Wrap: 40 interleaved write/read pairs with DEPTH=16 -> all 40 words returned in order.
REQ-038 Show-ahead: SHOWAHEAD=1, write 0xABCD into an empty FIFO -> the next cycle has empty=0 and q=0xABCD before any rdreq.
REQ-039 Error flags and reset: with FIFO_SYNC_ERRFLAGS_EN defined, wrreq while full -> overflow=1 and stays 1. Pulsing aclr mid-stream -> overflow=0, usedw=0, empty=1 immediately.
